// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage registers: stage modes, payload widths, reset values.
package pipe_pkg;

    localparam int unsigned PIPE_MODE_PASS = 0;
    localparam int unsigned PIPE_MODE_SKID = 1;

    // Payload widths of the inter-stage latches
    localparam int unsigned IFID_W  = 96;   // instr + PC + PC+4
    localparam int unsigned IDEX_W  = 160;  // PC, rs1/rs2 data, imm, ctrl
    localparam int unsigned EXMEM_W = 112;  // alu result, store data, rd, ctrl
    localparam int unsigned MEMWB_W = 72;   // writeback data, rd, ctrl

    localparam int unsigned PERF_CNT_W = 32;

    // Canonical NOP (addi x0, x0, 0), a natural reset value for instruction fields
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable; cleared only by reset.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    output logic [PERF_CNT_W-1:0] cnt_o
);

    logic [PERF_CNT_W-1:0] cnt_q;
    logic [PERF_CNT_W-1:0] cnt_d;

    // Increment on enable, sticking at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {PERF_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + PERF_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, stall and flush.
// MODE 0: single entry, in_ready depends on out_ready.
// MODE 1: main + skid entry, in_ready depends only on registered state.
// Optional: define PIPE_STAGE_PERF_EN to add stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W  = IFID_W,
    parameter int unsigned       MODE    = PIPE_MODE_PASS,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles,
`endif
    output logic [1:0]        count
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [1:0]        count_q,      count_d;
    logic              in_fire;
    logic              out_fire;

    // Acceptance: skid mode keeps out_ready off the in_ready path
    always_comb begin
        if (MODE == PIPE_MODE_SKID) begin
            in_ready = !stall_i && !skid_valid_q;
        end else begin
            in_ready = !stall_i && (!main_valid_q || out_ready);
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready && !stall_i;

    // Next-state: flush beats stall beats normal movement
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_VAL;
            skid_valid_d = 1'b0;
            skid_data_d  = RST_VAL;
        end else if (stall_i) begin
            // contents frozen
        end else if (MODE == PIPE_MODE_SKID) begin
            if (out_fire) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_data_d = in_data;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                if (!main_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end
        end else begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end

        count_d = 2'(main_valid_d) + 2'(skid_valid_d);
    end

    // State registers; reset empties the stage immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RST_VAL;
            count_q      <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            count_q      <= count_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign count     = count_q;

`ifdef PIPE_STAGE_PERF_EN
    // Held valid payload blocked by a stall
    pipe_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (stall_i && main_valid_q),
        .cnt_o (stall_cycles)
    );

    // Downstream ready but nothing to deliver
    pipe_perf_cnt u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!main_valid_q && out_ready && !stall_i),
        .cnt_o (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one pass-mode and one skid-mode instance on shared inputs.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        stall_i;
    logic        in_valid;
    logic [95:0] in_data;
    logic        out_ready;

    logic        p_in_ready, p_out_valid;
    logic [95:0] p_out_data;
    logic [1:0]  p_count;
    logic        s_in_ready, s_out_valid;
    logic [95:0] s_out_data;
    logic [1:0]  s_count;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] p_stall_cyc, p_bubble_cyc, s_stall_cyc, s_bubble_cyc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .MODE(0), .RST_VAL(96'h0)) dut_p (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .in_valid      (in_valid),
        .in_ready      (p_in_ready),
        .in_data       (in_data),
        .out_valid     (p_out_valid),
        .out_ready     (out_ready),
        .out_data      (p_out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles  (p_stall_cyc),
        .bubble_cycles (p_bubble_cyc),
`endif
        .count         (p_count)
    );

    pipe_stage_reg #(.DATA_W(96), .MODE(1), .RST_VAL(96'h0)) dut_s (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .in_data       (in_data),
        .out_valid     (s_out_valid),
        .out_ready     (out_ready),
        .out_data      (s_out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles  (s_stall_cyc),
        .bubble_cycles (s_bubble_cyc),
`endif
        .count         (s_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        stall_i   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_p_valid", 128'(p_out_valid), 128'd0);
        chk("rst_s_valid", 128'(s_out_valid), 128'd0);
        chk("rst_s_count", 128'(s_count), 128'd0);

        // Mid-stream asynchronous reset
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 96'hA5;
        out_ready = 1'b1;
        step();
        chk("pre_rst_p_data", 128'(p_out_data), 128'hA5);
        chk("pre_rst_s_data", 128'(s_out_data), 128'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p_valid", 128'(p_out_valid), 128'd0);
        chk("arst_p_data",  128'(p_out_data),  128'd0);
        chk("arst_p_count", 128'(p_count),     128'd0);
        chk("arst_s_valid", 128'(s_out_valid), 128'd0);
        chk("arst_s_data",  128'(s_out_data),  128'd0);
        chk("arst_s_count", 128'(s_count),     128'd0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_p_in_ready", 128'(p_in_ready), 128'd1);
        chk("rel_s_in_ready", 128'(s_in_ready), 128'd1);

        // Back-to-back streaming, both modes
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 96'(i);
            #1;
            chk("strm_p_in_ready", 128'(p_in_ready), 128'd1);
            chk("strm_s_in_ready", 128'(s_in_ready), 128'd1);
            step();
            chk("strm_p_data",  128'(p_out_data),  128'(i));
            chk("strm_s_data",  128'(s_out_data),  128'(i));
            chk("strm_s_valid", 128'(s_out_valid), 128'd1);
            chk("strm_s_count", 128'(s_count),     128'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_p_valid", 128'(p_out_valid), 128'd0);
        chk("drain_p_hold",  128'(p_out_data),  128'd8);
        chk("drain_s_hold",  128'(s_out_data),  128'd8);
        chk("drain_p_count", 128'(p_count),     128'd0);

        // Skid backpressure
        out_ready = 1'bx;
        #1;
        chk("skid_x_empty_ready", 128'(s_in_ready), 128'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 96'(i);
            step();
            chk("skid_pre_data", 128'(s_out_data), 128'(i));
        end
        in_data   = 96'd4;
        out_ready = 1'b0;
        #1;
        chk("skid_accept4_ready", 128'(s_in_ready), 128'd1);
        step();
        chk("skid_full_count", 128'(s_count),     128'd2);
        chk("skid_full_data",  128'(s_out_data),  128'd3);
        chk("skid_full_valid", 128'(s_out_valid), 128'd1);
        in_data = 96'd5;
        #1;
        chk("skid_full_in_ready", 128'(s_in_ready), 128'd0);
        out_ready = 1'bx;
        #1;
        chk("skid_x_iso_ready", 128'(s_in_ready), 128'd0);
        out_ready = 1'b1;
        step();
        chk("skid_emit4_data",  128'(s_out_data), 128'd4);
        chk("skid_emit4_count", 128'(s_count),    128'd1);
        #1;
        chk("skid_reopen_ready", 128'(s_in_ready), 128'd1);
        step();
        chk("skid_emit5_data",  128'(s_out_data), 128'd5);
        chk("skid_emit5_count", 128'(s_count),    128'd1);
        in_valid = 1'b0;
        step();
        chk("skid_empty_valid", 128'(s_out_valid), 128'd0);
        chk("skid_empty_count", 128'(s_count),     128'd0);
        step();
        chk("skid_p_empty", 128'(p_out_valid), 128'd0);

        // Stall with a valid payload held
        in_valid = 1'b1;
        in_data  = 96'd7;
        step();
        chk("stall_pre_p_data", 128'(p_out_data), 128'd7);
        chk("stall_pre_s_data", 128'(s_out_data), 128'd7);
        in_data = 96'd8;
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_p_in_ready", 128'(p_in_ready), 128'd0);
            chk("stall_s_in_ready", 128'(s_in_ready), 128'd0);
            step();
            chk("stall_p_data",  128'(p_out_data),  128'd7);
            chk("stall_s_data",  128'(s_out_data),  128'd7);
            chk("stall_p_valid", 128'(p_out_valid), 128'd1);
            chk("stall_s_count", 128'(s_count),     128'd1);
        end
        stall_i = 1'b0;
        step();
        chk("unstall_p_data", 128'(p_out_data), 128'd8);
        chk("unstall_s_data", 128'(s_out_data), 128'd8);

        // Flush together with stall while skid is full
        in_data   = 96'd9;
        out_ready = 1'b0;
        step();
        chk("fl_pre_s_count", 128'(s_count),    128'd2);
        chk("fl_pre_p_count", 128'(p_count),    128'd1);
        chk("fl_pre_p_data",  128'(p_out_data), 128'd8);
        flush_i   = 1'b1;
        stall_i   = 1'b1;
        in_data   = 96'd10;
        out_ready = 1'b1;
        step();
        chk("fl_s_count", 128'(s_count),     128'd0);
        chk("fl_s_valid", 128'(s_out_valid), 128'd0);
        chk("fl_s_data",  128'(s_out_data),  128'd0);
        chk("fl_p_count", 128'(p_count),     128'd0);
        chk("fl_p_data",  128'(p_out_data),  128'd0);
        flush_i  = 1'b0;
        stall_i  = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_discard_s_valid", 128'(s_out_valid), 128'd0);
        chk("fl_discard_p_valid", 128'(p_out_valid), 128'd0);

        // Flush alone: in_ready not gated, incoming word dropped
        flush_i  = 1'b1;
        in_valid = 1'b1;
        in_data  = 96'd11;
        #1;
        chk("fl2_p_in_ready", 128'(p_in_ready), 128'd1);
        chk("fl2_s_in_ready", 128'(s_in_ready), 128'd1);
        step();
        chk("fl2_p_valid", 128'(p_out_valid), 128'd0);
        chk("fl2_s_data",  128'(s_out_data),  128'd0);
        flush_i  = 1'b0;
        in_valid = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Performance counters
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("perf_rst_stall",  128'(p_stall_cyc),  128'd0);
        chk("perf_rst_bubble", 128'(p_bubble_cyc), 128'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("perf_bubble_p", 128'(p_bubble_cyc), 128'd4);
        chk("perf_bubble_s", 128'(s_bubble_cyc), 128'd4);
        in_valid = 1'b1;
        in_data  = 96'd1;
        step();
        in_valid = 1'b0;
        stall_i  = 1'b1;
        repeat (5) step();
        chk("perf_stall_p", 128'(p_stall_cyc), 128'd5);
        chk("perf_stall_s", 128'(s_stall_cyc), 128'd5);
        force dut_p.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_p.u_stall_cnt.cnt_q;
        step();
        chk("perf_sat_reach", 128'(p_stall_cyc), 128'hFFFF_FFFF);
        step();
        chk("perf_sat_hold", 128'(p_stall_cyc), 128'hFFFF_FFFF);
        stall_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register with a valid/ready handshake, stall and flush. It generalises the fixed IF/ID latch to any payload width and adds valid tracking, so bubbles are explicit. It also offers two modes: pass-through (single entry) and skid (two entries, fully registered ready). It is instantiated between every pair of stages: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 96, payload width in bits (IF/ID: instr + PC + PC+4).
- MODE, 0, 0 = pass (1 entry, ready combinational from out_ready); 1 = skid (2 entries, no out_ready->in_ready path).
- RST_VAL, {DATA_W{1'b0}}, value of out_data after reset or flush.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all held entries.
- stall_i  in  1  hold: no accept, no release; contents frozen.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload at output is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to next stage.
- count  out  2  entries held (0..2; never exceeds 1 when MODE=0).

Behaviour:
- Fires: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & !stall_i.
- Reset (rst_n=0, async): out_valid=0, out_data=RST_VAL, count=0, skid entry empty. After release, in_ready=!stall_i.
- Priority at each edge: flush_i > stall_i > normal.
- Flush: all entries are invalidated and out_data=RST_VAL on the next edge. An in_fire in the same cycle is discarded. in_ready is not gated by flush.
- Stall: in_ready=0. Registers hold, out_valid is unchanged, no out_fire occurs. stall_i reaches in_ready combinationally; stall_i must come from the registered hazard unit.
- MODE=0:
  - in_ready = !stall_i & (!out_valid | out_ready).
  - On in_fire: out_data<=in_data, out_valid<=1.
  - On out_fire without in_fire: out_valid<=0, out_data holds.
  - Latency 1 cycle. Full throughput.
- MODE=1: main entry drives the outputs; the skid entry is internal. in_ready = !stall_i & !skid_valid (registered term).
  - in_fire while main empty, or with out_fire: load main.
  - in_fire while main valid and no out_fire: load skid, so count=2.
  - out_fire while skid valid: skid->main, skid cleared. in_fire cannot coincide, since in_ready=0.
  - Latency 1 cycle. Full throughput while out_ready=1.
- Data registers load only on the events above. Bubbles leave out_data at its last value; only reset and flush force RST_VAL.
- Payload ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- Reset asserted mid-transfer: immediate empty state, no partial update.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds output ports stall_cycles [31:0] and bubble_cycles [31:0].
  - stall_cycles increments when stall_i & out_valid.
  - bubble_cycles increments when !out_valid & out_ready & !stall_i.
  - Both saturate at 32'hFFFFFFFF, clear only on rst_n (not on flush), and read 0 after reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - localparams PIPE_MODE_PASS=0 and PIPE_MODE_SKID=1;
  - stage payload widths IFID_W=96, IDEX_W, EXMEM_W, MEMWB_W;
  - NOP_INSTR=32'h00000013, a candidate RST_VAL for instruction fields.
- One sub-module, pipe_perf_cnt: 32-bit saturating counter with enable. It is instantiated twice, only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: hold rst_n=0 mid-stream with in_valid=1 and in_data=96'hA5 -> out_valid=0, out_data=0, count=0 immediately. in_ready=1 after release.
- Streaming, both modes: out_ready=1 and 8 back-to-back in_data 1..8 -> out_data 1..8 in order, one per cycle, first at 1-cycle latency, in_ready constantly 1.
- Skid backpressure, MODE=1: drop out_ready after word 3 is accepted -> word 4 captured in skid, count=2, in_ready=0 next cycle. Raise out_ready -> 3,4,5 emerge with none lost. out_ready->in_ready has no combinational path (check by forcing out_ready X).
- Stall: stall_i=1 for 3 cycles with out_valid=1, out_ready=1, out_data=7 -> out_data stays 7, in_ready=0, no out_fire. Next word appears 1 cycle after release.
- Flush vs stall: flush_i=1 and stall_i=1 together, count=2, with in_fire attempted -> next edge count=0, out_valid=0, out_data=RST_VAL, incoming word discarded.
- Perf (PIPE_STAGE_PERF_EN): 5 stalled-valid cycles and 4 empty-ready cycles -> stall_cycles=5, bubble_cycles=4. Preload near saturation via force -> counters hold at FFFFFFFF.
